chorus_sample_scheduler: RTL and testbench
==========================================

Name: chorus_sample_scheduler

Overview:
Per-sample sequencer for the chorus DSP chain in the clkDSP (6 MHz) domain, sitting between the STF CDC FIFO output and the FTS CDC FIFO input. For each dry sample it fetches an LFO delay offset, writes the sample into the delay buffer FSM, and waits for the wet sample. It then mixes wet and dry and hands the result to the TX FIFO. It also detects sample overruns and wet-read timeouts and reports them on the error LED.

Parameters:
PKT_WIDTH, 16, audio sample width (signed two's complement)
LFO_WIDTH, 13, delay-offset width (covers 4410-sample buffer)
MIX_WIDTH, 8, wet-mix weight width
TIMEOUT_CYC, 96, max clk cycles in WAIT_WET (< 136 clk cycles per 44.1 kHz sample)
CNT_WIDTH, 8, overrun counter width

Ports:
clk  in  1  DSP clock (clkDSP)
rst_n  in  1  asynchronous active-low reset
pktDry_i  in  PKT_WIDTH  dry sample from STF CDC FIFO
pktDryValid_i  in  1  one-cycle strobe, new dry sample
lfoReq_o  out  1  request next LFO offset
lfoAck_i  in  1  LFO offset valid; accepted while lfoReq_o=1
lfoDelay_i  in  LFO_WIDTH  LFO offset
dlyPkt_o  out  PKT_WIDTH  sample to delay buffer
dlyPktValid_o  out  1  one-cycle write strobe to delay buffer
dlyExtra_o  out  LFO_WIDTH  latched extra delay to delay buffer
dlyWet_i  in  PKT_WIDTH  delayed (wet) sample
dlyWetValid_i  in  1  wet-valid strobe
mix_i  in  MIX_WIDTH  wet weight, 0..255 (sampled at sample start)
bypass_i  in  1  force dry-only output (sampled at sample start)
txPkt_o  out  PKT_WIDTH  mixed sample to FTS CDC FIFO
txValid_o  out  1  held until txReady_i
txReady_i  in  1  TX FIFO can accept
errClr_i  in  1  clears sticky errors and the overrun counter
overrunCnt_o  out  CNT_WIDTH  saturating count of dropped dry samples
errorLED_o  out  1  sticky OR of timeoutErr and overrunErr

Behaviour:
- Reset: state IDLE. lfoReq_o, dlyPktValid_o and txValid_o are 0. dlyPkt_o, dlyExtra_o, txPkt_o, overrunCnt_o and errorLED_o are 0. Internal registers are cleared. A reset asserted mid-sample aborts that sample; nothing is emitted.
- IDLE: on pktDryValid_i, latch pktDry_i, mix_i and bypass_i, then go to LFO_REQ.
- LFO_REQ: lfoReq_o=1. When lfoAck_i=1, latch lfoDelay_i and go to WRITE. An ack in the same cycle as the request is legal. Wait indefinitely for the ack.
- WRITE: dlyPktValid_o=1 for exactly one cycle. dlyPkt_o carries the dry sample and dlyExtra_o carries the latched offset; dlyExtra_o holds its value until the next WRITE. Clear the timer, then go to WAIT_WET.
- WAIT_WET: when dlyWetValid_i=1, latch dlyWet_i and go to MIX. Otherwise the timer increments each cycle. If the timer reaches TIMEOUT_CYC-1 without a wet-valid, set timeoutErr, substitute wet:=dry and go to MIX. A wet-valid arriving on the timeout cycle takes precedence.
- MIX: one registered cycle. The result is floor((dry*(256-w) + wet*w) / 256), using a signed product and an arithmetic shift right by 8. w = 0 if bypass is latched, otherwise w = mix. Intermediate width is PKT_WIDTH+10 bits. This is a convex combination, so the result needs no saturation. Go to PUSH.
- PUSH: txValid_o=1 and txPkt_o are stable until txReady_i=1. On that handshake cycle go to IDLE; txValid_o falls on the next cycle.
- Best-case latency: dry strobe at cycle N, then LFO_REQ at N+1 (immediate ack), WRITE at N+2, wet strobe at N+3, MIX at N+4, txValid_o=1 at N+5.
- Overrun: a pktDryValid_i in any state other than IDLE drops that sample. overrunErr is set and overrunCnt_o increments, saturating at all-ones.
- errClr_i clears timeoutErr, overrunErr and overrunCnt_o. If errClr_i coincides with a new error event, the set wins.
- Stray lfoAck_i or dlyWetValid_i outside its own state is ignored.

Decomposition:
- Package dsp_pkg holds:
  - the state enum (IDLE, LFO_REQ, WRITE, WAIT_WET, MIX, PUSH)
  - PKT_WIDTH, LFO_WIDTH and MIX_WIDTH defaults
  - the mix arithmetic as a function
- Sub-module wet_dry_mixer: registered one-cycle mix with signed arithmetic, instantiated for the MIX stage.

Test Plan:
- Dry=16'h1000, immediate ack with delay=300, wet=16'h2000 at N+3, mix=128, txReady=1 -> dlyExtra_o=300, txPkt_o=16'h1800 with txValid_o=1 at N+5.
- Dry=-16'sd1000, wet=+16'sd1000, mix=255 -> txPkt_o=floor((-1000*1 + 1000*255)/256)=992. Repeat with bypass_i=1 -> txPkt_o=-1000.
- No dlyWetValid_i after WRITE -> after 96 cycles in WAIT_WET, timeoutErr and errorLED_o=1 and txPkt_o=dry. Then errClr_i -> errorLED_o=0.
- Second pktDryValid_i while in WAIT_WET -> sample dropped, overrunCnt_o=1, errorLED_o=1. Inject 300 overruns -> overrunCnt_o=255.
- lfoAck delayed 10 cycles and txReady_i low for 20 cycles -> lfoReq_o held throughout the wait; txValid_o and txPkt_o stable throughout; exactly one dlyPktValid_o pulse and one TX transfer.
- Assert rst_n=0 during PUSH -> txValid_o=0 immediately (asynchronous). After release, state IDLE and the next sample is processed normally.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared types, default widths and mix arithmetic for the chorus DSP chain.
// Imported by the sample scheduler and the wet/dry mixer.
package dsp_pkg;

  localparam int DEF_PKT_WIDTH = 16;
  localparam int DEF_LFO_WIDTH = 13;
  localparam int DEF_MIX_WIDTH = 8;
  localparam int ACC_WIDTH     = DEF_PKT_WIDTH + 10;

  typedef enum logic [2:0] {
    IDLE,
    LFO_REQ,
    WRITE,
    WAIT_WET,
    MIX,
    PUSH
  } schedState_t;

  // Convex wet/dry blend; w/256 is the wet weight.
  // The arithmetic shift floors toward -inf.
  function automatic logic [DEF_PKT_WIDTH-1:0] mixSample(
    input logic [DEF_PKT_WIDTH-1:0] dry,
    input logic [DEF_PKT_WIDTH-1:0] wet,
    input logic [DEF_MIX_WIDTH-1:0] w
  );
    logic signed [ACC_WIDTH-1:0] dX;
    logic signed [ACC_WIDTH-1:0] wX;
    logic signed [ACC_WIDTH-1:0] dW;
    logic signed [ACC_WIDTH-1:0] wW;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] shr;
    dX  = ACC_WIDTH'($signed(dry));
    wX  = ACC_WIDTH'($signed(wet));
    wW  = ACC_WIDTH'(int'(w));
    dW  = ACC_WIDTH'(256 - int'(w));
    acc = dX * dW + wX * wW;
    shr = acc >>> DEF_MIX_WIDTH;
    return shr[DEF_PKT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/wet_dry_mixer.sv
// Registered one-cycle wet/dry mixer; loads when en is high.
// Ports: clk, rst_n, en, dry, wet, weight, bypass -> mixOut.
module wet_dry_mixer
  import dsp_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [DEF_PKT_WIDTH-1:0] dry,
  input  logic [DEF_PKT_WIDTH-1:0] wet,
  input  logic [DEF_MIX_WIDTH-1:0] weight,
  input  logic                     bypass,
  output logic [DEF_PKT_WIDTH-1:0] mixOut
);

  logic [DEF_MIX_WIDTH-1:0] wEff;

  assign wEff = bypass ? '0 : weight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mixOut <= '0;
    end else if (en) begin
      mixOut <= mixSample(dry, wet, wEff);
    end
  end

endmodule

// File: rtl/chorus_sample_scheduler.sv
// Per-sample chorus sequencer: LFO fetch, delay write, wet wait, mix, TX.
// Ports: dry in, LFO req/ack, delay buffer write/read, TX handshake, errors.
module chorus_sample_scheduler
  import dsp_pkg::*;
#(
  parameter int PKT_WIDTH   = DEF_PKT_WIDTH,
  parameter int LFO_WIDTH   = DEF_LFO_WIDTH,
  parameter int MIX_WIDTH   = DEF_MIX_WIDTH,
  parameter int TIMEOUT_CYC = 96,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PKT_WIDTH-1:0] pktDry_i,
  input  logic                 pktDryValid_i,
  output logic                 lfoReq_o,
  input  logic                 lfoAck_i,
  input  logic [LFO_WIDTH-1:0] lfoDelay_i,
  output logic [PKT_WIDTH-1:0] dlyPkt_o,
  output logic                 dlyPktValid_o,
  output logic [LFO_WIDTH-1:0] dlyExtra_o,
  input  logic [PKT_WIDTH-1:0] dlyWet_i,
  input  logic                 dlyWetValid_i,
  input  logic [MIX_WIDTH-1:0] mix_i,
  input  logic                 bypass_i,
  output logic [PKT_WIDTH-1:0] txPkt_o,
  output logic                 txValid_o,
  input  logic                 txReady_i,
  input  logic                 errClr_i,
  output logic [CNT_WIDTH-1:0] overrunCnt_o,
  output logic                 errorLED_o
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC);

  schedState_t state;
  schedState_t stateNxt;

  logic [PKT_WIDTH-1:0] dryQ;
  logic [PKT_WIDTH-1:0] wetQ;
  logic [MIX_WIDTH-1:0] mixQ;
  logic                 bypassQ;
  logic [LFO_WIDTH-1:0] extraQ;
  logic [TMR_W-1:0]     tmr;
  logic [CNT_WIDTH-1:0] ovCnt;
  logic                 timeoutErr;
  logic                 overrunErr;
  logic                 mixEn;
  logic                 tmrDone;
  logic                 overrun;
  logic                 timeoutHit;

  assign tmrDone = (tmr == TMR_W'(TIMEOUT_CYC - 1));
  assign overrun = pktDryValid_i && (state != IDLE);

  // Wet-valid on the final timer cycle wins over the timeout.
  assign timeoutHit = (state == WAIT_WET) &&
                      !dlyWetValid_i && tmrDone;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  always_comb begin
    stateNxt      = state;
    lfoReq_o      = 1'b0;
    dlyPktValid_o = 1'b0;
    txValid_o     = 1'b0;
    mixEn         = 1'b0;
    unique case (state)
      IDLE: begin
        if (pktDryValid_i) stateNxt = LFO_REQ;
      end
      LFO_REQ: begin
        lfoReq_o = 1'b1;
        if (lfoAck_i) stateNxt = WRITE;
      end
      WRITE: begin
        dlyPktValid_o = 1'b1;
        stateNxt      = WAIT_WET;
      end
      WAIT_WET: begin
        if (dlyWetValid_i || tmrDone) stateNxt = MIX;
      end
      MIX: begin
        mixEn    = 1'b1;
        stateNxt = PUSH;
      end
      PUSH: begin
        txValid_o = 1'b1;
        if (txReady_i) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dryQ    <= '0;
      wetQ    <= '0;
      mixQ    <= '0;
      bypassQ <= 1'b0;
      extraQ  <= '0;
      tmr     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pktDryValid_i) begin
            dryQ    <= pktDry_i;
            mixQ    <= mix_i;
            bypassQ <= bypass_i;
          end
        end
        LFO_REQ: begin
          if (lfoAck_i) extraQ <= lfoDelay_i;
        end
        WRITE: begin
          tmr <= '0;
        end
        WAIT_WET: begin
          if (dlyWetValid_i) begin
            wetQ <= dlyWet_i;
          end else if (tmrDone) begin
            wetQ <= dryQ;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Error set wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeoutErr <= 1'b0;
      overrunErr <= 1'b0;
      ovCnt      <= '0;
    end else begin
      if (timeoutHit) begin
        timeoutErr <= 1'b1;
      end else if (errClr_i) begin
        timeoutErr <= 1'b0;
      end
      if (overrun) begin
        overrunErr <= 1'b1;
        if (errClr_i) begin
          ovCnt <= CNT_WIDTH'(1);
        end else if (ovCnt != '1) begin
          ovCnt <= ovCnt + CNT_WIDTH'(1);
        end
      end else if (errClr_i) begin
        overrunErr <= 1'b0;
        ovCnt      <= '0;
      end
    end
  end

  wet_dry_mixer uMixer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (mixEn),
    .dry    (dryQ),
    .wet    (wetQ),
    .weight (mixQ),
    .bypass (bypassQ),
    .mixOut (txPkt_o)
  );

  assign dlyPkt_o     = dryQ;
  assign dlyExtra_o   = extraQ;
  assign overrunCnt_o = ovCnt;
  assign errorLED_o   = timeoutErr | overrunErr;

endmodule

// File: tb/tb_chorus_sample_scheduler.sv
// Self-checking bench for chorus_sample_scheduler.
// Drives at negedge, samples at negedge; reference mix by plain integer math.
module tb_chorus_sample_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pktDry_i;
  logic        pktDryValid_i;
  logic        lfoReq_o;
  logic        lfoAck_i;
  logic [12:0] lfoDelay_i;
  logic [15:0] dlyPkt_o;
  logic        dlyPktValid_o;
  logic [12:0] dlyExtra_o;
  logic [15:0] dlyWet_i;
  logic        dlyWetValid_i;
  logic [7:0]  mix_i;
  logic        bypass_i;
  logic [15:0] txPkt_o;
  logic        txValid_o;
  logic        txReady_i;
  logic        errClr_i;
  logic [7:0]  overrunCnt_o;
  logic        errorLED_o;

  int nCmp = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  chorus_sample_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pktDry_i      (pktDry_i),
    .pktDryValid_i (pktDryValid_i),
    .lfoReq_o      (lfoReq_o),
    .lfoAck_i      (lfoAck_i),
    .lfoDelay_i    (lfoDelay_i),
    .dlyPkt_o      (dlyPkt_o),
    .dlyPktValid_o (dlyPktValid_o),
    .dlyExtra_o    (dlyExtra_o),
    .dlyWet_i      (dlyWet_i),
    .dlyWetValid_i (dlyWetValid_i),
    .mix_i         (mix_i),
    .bypass_i      (bypass_i),
    .txPkt_o       (txPkt_o),
    .txValid_o     (txValid_o),
    .txReady_i     (txReady_i),
    .errClr_i      (errClr_i),
    .overrunCnt_o  (overrunCnt_o),
    .errorLED_o    (errorLED_o)
  );

  // floor((dry*(256-w) + wet*w) / 256) with explicit floor division.
  function automatic logic [15:0] refMix(
    input logic [15:0] dry,
    input logic [15:0] wet,
    input int w,
    input bit byp
  );
    int ww, s, q;
    ww = byp ? 0 : w;
    s  = int'($signed(dry)) * (256 - ww)
       + int'($signed(wet)) * ww;
    q  = s / 256;
    if ((s % 256 != 0) && (s < 0)) q = q - 1;
    return 16'(q);
  endfunction

  task automatic pulseClr();
    @(negedge clk);
    errClr_i = 1'b1;
    @(negedge clk);
    errClr_i = 1'b0;
  endtask

  // Runs one sample through the DUT acting as LFO, delay buffer and TX FIFO.
  task automatic runSample(
    input  logic [15:0] dry,
    input  logic [15:0] wet,
    input  int          w,
    input  bit          byp,
    input  logic [12:0] dly,
    input  int          ackDly,
    input  int          wetDly,
    input  int          rdyDly,
    output logic [15:0] txOut,
    output int          lat,
    output int          reqCyc,
    output int          pulses,
    output logic [15:0] pktSeen,
    output logic [12:0] extraSeen,
    output int          txCyc,
    output int          unstable,
    output int          xfers
  );
    int cyc, ww;
    bit done, hs, wrote, wetGiven;
    txOut = '0; lat = -1; reqCyc = 0; pulses = 0;
    pktSeen = '0; extraSeen = '0; txCyc = 0;
    unstable = 0; xfers = 0;
    cyc = 0; ww = 0; done = 0; hs = 0;
    wrote = 0; wetGiven = 0;
    @(negedge clk);
    pktDry_i = dry; mix_i = 8'(w); bypass_i = byp;
    lfoDelay_i = dly; dlyWet_i = wet;
    pktDryValid_i = 1'b1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      pktDryValid_i = 1'b0;
      if (hs) begin
        done = 1;
        if (txValid_o) unstable++;
      end
      lfoAck_i = 1'b0;
      if (lfoReq_o) begin
        reqCyc++;
        if (reqCyc > ackDly) lfoAck_i = 1'b1;
      end
      dlyWetValid_i = 1'b0;
      if (dlyPktValid_o) begin
        pulses++;
        pktSeen = dlyPkt_o;
        extraSeen = dlyExtra_o;
        wrote = 1; ww = 0;
      end else if (wrote && !wetGiven) begin
        ww++;
        if (wetDly >= 0 && ww - 1 == wetDly) begin
          dlyWetValid_i = 1'b1;
          wetGiven = 1;
        end
      end
      txReady_i = 1'b0;
      if (txValid_o && !hs) begin
        if (txCyc == 0) begin
          txOut = txPkt_o;
          lat = cyc;
        end else if (txPkt_o !== txOut) begin
          unstable++;
        end
        txCyc++;
        if (txCyc > rdyDly) begin
          txReady_i = 1'b1;
          xfers++;
          hs = 1;
        end
      end
    end
    lfoAck_i = 1'b0; dlyWetValid_i = 1'b0; txReady_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (dlyPktValid_o) pulses++;
      if (txValid_o) xfers++;
    end
    nCmp++;
    if (!done) begin
      nBad++;
      $display("FAIL runSample_bound: got no TX handshake in %0d cycles, required one", cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pktDry_i = '0; pktDryValid_i = 0; lfoAck_i = 0;
    lfoDelay_i = '0; dlyWet_i = '0; dlyWetValid_i = 0;
    mix_i = '0; bypass_i = 0; txReady_i = 0; errClr_i = 0;
    @(negedge clk);
    @(negedge clk);
    nCmp++;
    if ({lfoReq_o, dlyPktValid_o, txValid_o, errorLED_o} !== 4'b0) begin
      nBad++;
      $display("FAIL reset_ctl: got %b required 0000",
        {lfoReq_o, dlyPktValid_o, txValid_o, errorLED_o});
    end
    nCmp++;
    if ({dlyPkt_o, dlyExtra_o, txPkt_o, overrunCnt_o} !== '0) begin
      nBad++;
      $display("FAIL reset_data: got %h/%h/%h/%h required all 0",
        dlyPkt_o, dlyExtra_o, txPkt_o, overrunCnt_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] tx, pk; logic [12:0] ex;
    int lat, rq, pu, tc, un, xf;
    runSample(16'h1000, 16'h2000, 128, 0, 13'd300, 0, 0, 0,
      tx, lat, rq, pu, pk, ex, tc, un, xf);
    nCmp++;
    if (ex !== 13'd300) begin
      nBad++; $display("FAIL basic_extra: got %0d required 300", ex);
    end
    nCmp++;
    if (pk !== 16'h1000) begin
      nBad++; $display("FAIL basic_dlyPkt: got %h required 1000", pk);
    end
    nCmp++;
    if (tx !== 16'h1800) begin
      nBad++; $display("FAIL basic_tx: got %h required 1800", tx);
    end
    nCmp++;
    if (lat !== 5) begin
      nBad++; $display("FAIL basic_latency: got %0d required 5", lat);
    end
    nCmp++;
    if (pu !== 1 || xf !== 1) begin
      nBad++;
      $display("FAIL basic_counts: got pulses %0d xfers %0d required 1/1",
        pu, xf);
    end
  endtask

  task automatic test_mix_extremes();
    logic [15:0] tx, pk; logic [12:0] ex;
    int lat, rq, pu, tc, un, xf;
    runSample(16'hFC18, 16'd1000, 255, 0, 13'd7, 0, 1, 0,
      tx, lat, rq, pu, pk, ex, tc, un, xf);
    nCmp++;
    if (tx !== 16'd992) begin
      nBad++; $display("FAIL mix255: got %0d required 992", $signed(tx));
    end
    runSample(16'hFC18, 16'd1000, 255, 1, 13'd7, 0, 1, 0,
      tx, lat, rq, pu, pk, ex, tc, un, xf);
    nCmp++;
    if (tx !== 16'hFC18) begin
      nBad++;
      $display("FAIL mix_bypass: got %0d required -1000", $signed(tx));
    end
  endtask

  task automatic test_timeout();
    logic [15:0] tx, pk, exp; logic [12:0] ex;
    int lat, rq, pu, tc, un, xf;
    runSample(16'h0123, 16'h7FFF, 200, 0, 13'd5, 0, -1, 0,
      tx, lat, rq, pu, pk, ex, tc, un, xf);
    nCmp++;
    if (tx !== 16'h0123 || lat !== 100) begin
      nBad++;
      $display("FAIL timeout_tx: got %h lat %0d required 0123 lat 100",
        tx, lat);
    end
    nCmp++;
    if (errorLED_o !== 1'b1) begin
      nBad++; $display("FAIL timeout_led: got %b required 1", errorLED_o);
    end
    pulseClr();
    nCmp++;
    if (errorLED_o !== 1'b0) begin
      nBad++; $display("FAIL timeout_clr: got %b required 0", errorLED_o);
    end
    runSample(16'h0123, 16'h7FFF, 200, 0, 13'd5, 0, 95, 0,
      tx, lat, rq, pu, pk, ex, tc, un, xf);
    exp = refMix(16'h0123, 16'h7FFF, 200, 0);
    nCmp++;
    if (tx !== exp || lat !== 100 || errorLED_o !== 1'b0) begin
      nBad++;
      $display("FAIL wet_on_last: got %h lat %0d led %b required %h lat 100 led 0",
        tx, lat, errorLED_o, exp);
    end
  endtask

  task automatic test_overrun();
    int k;
    logic [15:0] exp;
    pulseClr();
    nCmp++;
    if (overrunCnt_o !== 8'd0) begin
      nBad++; $display("FAIL ovr_start: got %0d required 0", overrunCnt_o);
    end
    txReady_i = 1'b1; lfoAck_i = 1'b1; dlyWetValid_i = 1'b0;
    @(negedge clk);
    pktDry_i = 16'h0456; mix_i = 8'd64; bypass_i = 0;
    pktDryValid_i = 1'b1;
    @(negedge clk);
    pktDryValid_i = 1'b0;
    @(negedge clk);
    lfoAck_i = 1'b0;
    @(negedge clk);
    pktDry_i = 16'h7777;
    pktDryValid_i = 1'b1;
    @(negedge clk);
    pktDryValid_i = 1'b0;
    nCmp++;
    if (overrunCnt_o !== 8'd1 || errorLED_o !== 1'b1) begin
      nBad++;
      $display("FAIL ovr_one: got cnt %0d led %b required 1/1",
        overrunCnt_o, errorLED_o);
    end
    k = 0;
    while (!txValid_o && k < 200) begin
      @(negedge clk); k++;
    end
    nCmp++;
    if (txValid_o !== 1'b1 || txPkt_o !== 16'h0456) begin
      nBad++;
      $display("FAIL ovr_kept: got valid %b pkt %h required 1/0456",
        txValid_o, txPkt_o);
    end
    @(negedge clk);
    txReady_i = 1'b0;
    pktDry_i = 16'h0F00; mix_i = 8'd32;
    pktDryValid_i = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 300; i++) @(negedge clk);
    pktDryValid_i = 1'b0;
    nCmp++;
    if (overrunCnt_o !== 8'd255 || lfoReq_o !== 1'b1) begin
      nBad++;
      $display("FAIL ovr_sat: got cnt %0d req %b required 255/1",
        overrunCnt_o, lfoReq_o);
    end
    dlyWet_i = 16'hF000;
    lfoAck_i = 1'b1; dlyWetValid_i = 1'b1; txReady_i = 1'b1;
    k = 0;
    while (!txValid_o && k < 50) begin
      @(negedge clk); k++;
    end
    exp = refMix(16'h0F00, 16'hF000, 32, 0);
    nCmp++;
    if (txValid_o !== 1'b1 || txPkt_o !== exp) begin
      nBad++;
      $display("FAIL ovr_next: got valid %b pkt %h required 1/%h",
        txValid_o, txPkt_o, exp);
    end
    @(negedge clk);
    lfoAck_i = 1'b0; dlyWetValid_i = 1'b0; txReady_i = 1'b0;
    pulseClr();
    nCmp++;
    if (overrunCnt_o !== 8'd0 || errorLED_o !== 1'b0) begin
      nBad++;
      $display("FAIL ovr_clr: got cnt %0d led %b required 0/0",
        overrunCnt_o, errorLED_o);
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [15:0] tx, pk, exp; logic [12:0] ex;
    int lat, rq, pu, tc, un, xf;
    runSample(16'h2345, 16'hABCD, 77, 0, 13'd4095, 10, 2, 20,
      tx, lat, rq, pu, pk, ex, tc, un, xf);
    exp = refMix(16'h2345, 16'hABCD, 77, 0);
    nCmp++;
    if (rq !== 11) begin
      nBad++; $display("FAIL stall_req: got %0d cycles required 11", rq);
    end
    nCmp++;
    if (pu !== 1 || xf !== 1 || un !== 0) begin
      nBad++;
      $display("FAIL stall_once: got pulses %0d xfers %0d unstable %0d required 1/1/0",
        pu, xf, un);
    end
    nCmp++;
    if (tc !== 21 || lat !== 17 || tx !== exp) begin
      nBad++;
      $display("FAIL stall_tx: got cyc %0d lat %0d pkt %h required 21/17/%h",
        tc, lat, tx, exp);
    end
  endtask

  task automatic test_async_reset();
    int k;
    logic [15:0] tx, pk; logic [12:0] ex;
    int lat, rq, pu, tc, un, xf;
    lfoAck_i = 1'b1; dlyWetValid_i = 1'b1; txReady_i = 1'b0;
    dlyWet_i = 16'h4000;
    @(negedge clk);
    pktDry_i = 16'h1111; mix_i = 8'd100; bypass_i = 0;
    pktDryValid_i = 1'b1;
    @(negedge clk);
    pktDryValid_i = 1'b0;
    k = 0;
    while (!txValid_o && k < 50) begin
      @(negedge clk); k++;
    end
    nCmp++;
    if (txValid_o !== 1'b1) begin
      nBad++; $display("FAIL arst_push: got %b required 1", txValid_o);
    end
    #2 rst_n = 1'b0;
    #1;
    nCmp++;
    if (txValid_o !== 1'b0 || txPkt_o !== 16'h0) begin
      nBad++;
      $display("FAIL arst_immediate: got valid %b pkt %h required 0/0000",
        txValid_o, txPkt_o);
    end
    lfoAck_i = 1'b0; dlyWetValid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    runSample(16'hC000, 16'h3000, 192, 0, 13'd42, 0, 0, 0,
      tx, lat, rq, pu, pk, ex, tc, un, xf);
    nCmp++;
    if (tx !== refMix(16'hC000, 16'h3000, 192, 0) || lat !== 5) begin
      nBad++;
      $display("FAIL arst_after: got %h lat %0d required %h lat 5",
        tx, lat, refMix(16'hC000, 16'h3000, 192, 0));
    end
  endtask

  task automatic test_random();
    logic [15:0] tx, pk, dry, wet, exp; logic [12:0] ex, dly;
    int lat, rq, pu, tc, un, xf;
    int w, ad, wd, rd; bit byp;
    for (int n = 0; n < 24; n++) begin
      dry = 16'($urandom);
      wet = 16'($urandom);
      dly = 13'($urandom_range(0, 4409));
      w   = int'($urandom_range(0, 255));
      byp = ($urandom_range(0, 3) == 0);
      ad  = int'($urandom_range(0, 4));
      wd  = int'($urandom_range(0, 6));
      rd  = int'($urandom_range(0, 3));
      runSample(dry, wet, w, byp, dly, ad, wd, rd,
        tx, lat, rq, pu, pk, ex, tc, un, xf);
      exp = refMix(dry, wet, w, byp);
      nCmp++;
      if (tx !== exp) begin
        nBad++;
        $display("FAIL rand_tx[%0d]: got %h required %h", n, tx, exp);
      end
      nCmp++;
      if (lat !== 5 + ad + wd || ex !== dly || pk !== dry) begin
        nBad++;
        $display("FAIL rand_path[%0d]: got lat %0d extra %0d pkt %h required %0d/%0d/%h",
          n, lat, ex, pk, 5 + ad + wd, dly, dry);
      end
      nCmp++;
      if (pu !== 1 || xf !== 1 || un !== 0 || tc !== rd + 1) begin
        nBad++;
        $display("FAIL rand_hs[%0d]: got pulses %0d xfers %0d unstable %0d txcyc %0d",
          n, pu, xf, un, tc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mix_extremes();
    test_timeout();
    test_overrun();
    test_back_to_back_stall();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
